// File: rtl/pc_gen.sv
// Fetch-PC register: one-cycle redirect latency; requests held off by stall, pending branch or a slow I-cache.
// Optional PC_ALIGN_CHECK_EN keeps misaligned redirect targets and raises adel_o instead of truncating them.
module pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
    parameter int          FETCH_WIDTH = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [31:0]            new_pc_i,
    input  logic                   branch_flag_i,
    input  logic [31:0]            branch_to_addr_i,
    input  logic                   req_ready_i,
    output logic                   req_valid_o,
    output logic [31:0]            pc_o,
    output logic [FETCH_WIDTH-1:0] lane_mask_o,
    output logic                   kill_o,
    output logic                   adel_o
);

    localparam int STRIDE = 4 * FETCH_WIDTH;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_q, pend_d;
    logic        run_q;
    logic        fire;
    logic        load;
    logic        load_flush;
    logic [31:0] load_pc;
    logic [31:0] seq_pc;
    logic [31:0] ofs;
    logic        adel;

    assign seq_pc = (pc_q & ~32'(STRIDE - 1)) + 32'(STRIDE);
    assign ofs    = (pc_q >> 2) & 32'(FETCH_WIDTH - 1);

    assign req_valid_o = run_q && !stall_i && !pend_q && !adel;
    assign fire        = req_valid_o && req_ready_i;
    assign kill_o      = flush_i || (branch_flag_i && !stall_i) || (pend_q && !stall_i);
    assign pc_o        = pc_q;
    assign adel_o      = adel;

    always_comb begin
        lane_mask_o = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_mask_o[i] = (32'(i) >= ofs) && !adel;
        end
    end

    // A branch resolved while unstalled supersedes any buffered one.
    always_comb begin
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        load       = 1'b0;
        load_flush = 1'b0;
        load_pc    = pc_q;
        if (flush_i) begin
            load       = 1'b1;
            load_flush = 1'b1;
            load_pc    = new_pc_i;
            pend_d     = 1'b0;
        end else if (branch_flag_i && !stall_i) begin
            load    = 1'b1;
            load_pc = branch_to_addr_i;
            pend_d  = 1'b0;
        end else if (branch_flag_i && !pend_q) begin
            pend_d    = 1'b1;
            pend_pc_d = branch_to_addr_i;
        end else if (!branch_flag_i && pend_q && !stall_i) begin
            load    = 1'b1;
            load_pc = pend_pc_q;
            pend_d  = 1'b0;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic adel_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (fire) begin
            pc_d = seq_pc;
        end
    end

    // Only a flush can clear the error; later branches just accumulate it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adel_q <= 1'b0;
        end else if (load) begin
            adel_q <= (|load_pc[1:0]) || (adel_q && !load_flush);
        end
    end

    assign adel = adel_q;
`else
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc & ~32'h3;
        end else if (fire) begin
            pc_d = seq_pc;
        end
    end

    assign adel = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            run_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            run_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: FETCH_WIDTH=1 and =4 instances share stimulus and are checked every cycle against a behavioural model.
module tb_pc_gen;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit AEN = 1'b1;
`else
    localparam bit AEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, flush, br, rdy;
    logic [31:0] npc, bta;

    logic        rv1, kill1, adel1, mask1;
    logic [31:0] pc1;
    logic        rv4, kill4, adel4;
    logic [31:0] pc4;
    logic [3:0]  mask4;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    pc_gen #(.RESET_PC(32'hBFC0_0000), .FETCH_WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .new_pc_i(npc),
        .branch_flag_i(br), .branch_to_addr_i(bta), .req_ready_i(rdy),
        .req_valid_o(rv1), .pc_o(pc1), .lane_mask_o(mask1), .kill_o(kill1), .adel_o(adel1)
    );

    pc_gen #(.RESET_PC(32'hBFC0_0000), .FETCH_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .new_pc_i(npc),
        .branch_flag_i(br), .branch_to_addr_i(bta), .req_ready_i(rdy),
        .req_valid_o(rv4), .pc_o(pc4), .lane_mask_o(mask4), .kill_o(kill4), .adel_o(adel4)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ppc;
        bit          pend;
        bit          run;
        bit          adel;
    } ms_t;

    ms_t m1, m4;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_rv(ms_t s);
        return s.run && !stall && !s.pend && !s.adel;
    endfunction

    function automatic logic [3:0] exp_mask(ms_t s, int fw);
        logic [3:0] m = 4'b0;
        int o = int'((s.pc >> 2) % fw);
        if (!s.adel)
            for (int i = 0; i < fw; i++) if (i >= o) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] tgt(logic [31:0] t);
        return AEN ? t : (t & ~32'h3);
    endfunction

    function automatic bit mis(logic [31:0] t);
        return AEN && (t % 4 != 0);
    endfunction

    function automatic ms_t nxt(ms_t s, int fw);
        ms_t n = s;
        int unsigned stride = 4 * fw;
        if (rst) begin
            n.pc = 32'hBFC0_0000; n.pend = 0; n.run = 0; n.adel = 0;
            return n;
        end
        n.run = 1;
        if (flush) begin
            n.pc = tgt(npc); n.pend = 0; n.adel = mis(npc);
        end else if (br && !stall) begin
            n.pc = tgt(bta); n.pend = 0; n.adel = s.adel || mis(bta);
        end else if (br && stall && !s.pend) begin
            n.pend = 1; n.ppc = bta;
        end else if (br) begin
            n = n;
        end else if (s.pend && !stall) begin
            n.pc = tgt(s.ppc); n.pend = 0; n.adel = s.adel || mis(s.ppc);
        end else if (exp_rv(s) && rdy) begin
            n.pc = s.pc - (s.pc % stride) + stride;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m1 = nxt(m1, 1);
        m4 = nxt(m4, 4);
        if (rst) armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m1_pc", pc1, m1.pc);
            chk("m1_rv", 32'(rv1), 32'(exp_rv(m1)));
            chk("m1_mask", 32'(mask1), 32'(exp_mask(m1, 1)));
            chk("m1_kill", 32'(kill1), 32'(flush || (br && !stall) || (m1.pend && !stall)));
            chk("m1_adel", 32'(adel1), 32'(m1.adel));
            chk("m4_pc", pc4, m4.pc);
            chk("m4_rv", 32'(rv4), 32'(exp_rv(m4)));
            chk("m4_mask", 32'(mask4), 32'(exp_mask(m4, 4)));
            chk("m4_kill", 32'(kill4), 32'(flush || (br && !stall) || (m4.pend && !stall)));
            chk("m4_adel", 32'(adel4), 32'(m4.adel));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; br = 0; rdy = 1; npc = '0; bta = '0;
        tick(); tick();
        chk("rst_pc", pc1, 32'hBFC0_0000);
        chk("rst_rv", 32'(rv1), 32'd0);
        chk("rst_mask4", 32'(mask4), 32'hF);
        chk("rst_adel", 32'(adel4), 32'd0);

        rst = 0; #1;
        chk("rel_rv0", 32'(rv1), 32'd0);
        tick();
        chk("rel_pc0", pc1, 32'hBFC0_0000);
        chk("rel_rv1", 32'(rv1), 32'd1);
        tick();
        chk("seq_pc1", pc1, 32'hBFC0_0004);
        chk("seq_pc4", pc4, 32'hBFC0_0010);
        tick();
        chk("seq_pc1b", pc1, 32'hBFC0_0008);

        br = 1; bta = 32'h8000_0008; #1;
        chk("br_kill", 32'(kill4), 32'd1);
        tick(); br = 0; #1;
        chk("br_pc4", pc4, 32'h8000_0008);
        chk("br_mask4", 32'(mask4), 32'b1100);
        tick();
        chk("br_seq4", pc4, 32'h8000_0010);
        chk("br_seqmask", 32'(mask4), 32'hF);
        chk("br_seq1", pc1, 32'h8000_000C);

        stall = 1; br = 1; bta = 32'h8000_1000; #1;
        chk("st_rv", 32'(rv4), 32'd0);
        chk("st_kill", 32'(kill4), 32'd0);
        tick(); bta = 32'h8000_2000;
        tick(); br = 0;
        tick();
        chk("st_hold", pc4, 32'h8000_0010);
        stall = 0; #1;
        chk("pend_kill", 32'(kill4), 32'd1);
        chk("pend_rv", 32'(rv4), 32'd0);
        tick();
        chk("pend_pc4", pc4, 32'h8000_1000);
        chk("pend_pc1", pc1, 32'h8000_1000);
        chk("pend_rv1", 32'(rv4), 32'd1);
        chk("pend_kill0", 32'(kill4), 32'd0);

        stall = 1; br = 1; bta = 32'h8000_3000;
        tick();
        flush = 1; npc = 32'hBFC0_0380; bta = 32'h8000_4000; #1;
        chk("fl_kill", 32'(kill4), 32'd1);
        tick(); flush = 0; br = 0; stall = 0; #1;
        chk("fl_pc", pc4, 32'hBFC0_0380);
        chk("fl_nopend", 32'(kill4), 32'd0);
        chk("fl_rv", 32'(rv4), 32'd1);
        tick();
        chk("fl_seq4", pc4, 32'hBFC0_0390);

        flush = 1; npc = 32'hFFFF_FFFC;
        tick(); flush = 0; #1;
        chk("wr_pc", pc1, 32'hFFFF_FFFC);
        chk("wr_mask4", 32'(mask4), 32'b1000);
        tick();
        chk("wr_pc1", pc1, 32'h0);
        chk("wr_pc4", pc4, 32'h0);

        rdy = 0;
        tick(); tick(); tick();
        chk("rdy_hold1", pc1, 32'h0);
        chk("rdy_hold4", pc4, 32'h0);
        chk("rdy_rv", 32'(rv1), 32'd1);
        rdy = 1;

        br = 1; bta = 32'h8000_0002;
        tick(); br = 0; #1;
`ifdef PC_ALIGN_CHECK_EN
        chk("al_pc", pc4, 32'h8000_0002);
        chk("al_adel", 32'(adel4), 32'd1);
        chk("al_rv", 32'(rv4), 32'd0);
        chk("al_mask", 32'(mask4), 32'd0);
        flush = 1; npc = 32'hBFC0_0380;
        tick(); flush = 0; #1;
        chk("al_clr", 32'(adel4), 32'd0);
        chk("al_resume", 32'(rv4), 32'd1);
`else
        chk("al_pc", pc4, 32'h8000_0000);
        chk("al_adel", 32'(adel4), 32'd0);
        chk("al_mask", 32'(mask4), 32'hF);
`endif

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            rst   = ($urandom % 64) == 0;
            stall = ($urandom % 4) == 0;
            flush = ($urandom % 16) == 0;
            br    = ($urandom % 5) == 0;
            if (br && m4.pend && !stall) br = 0;
            rdy   = ($urandom % 4) != 0;
            a = $urandom;
            if ($urandom % 4 != 0) a = a & ~32'h3;
            if ($urandom % 8 == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
            npc = a;
            bta = $urandom;
            if ($urandom % 4 != 0) bta = bta & ~32'h3;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
